trigger_signal_detect: RTL and testbench

TRIGGER_SIGNAL_DETECT -- requirements
Module: trigger_signal_detect

---
 rtl/trigger_signal_detect_pkg.sv | 18 +
 rtl/trigger_signal_detect_sync_2ff.sv | 21 ++
 rtl/trigger_signal_detect.sv | 121 ++++++++++++
 tb/tb_trigger_signal_detect.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/trigger_signal_detect_pkg.sv
// Shared types and constants for the trigger signal detector.
package trigger_signal_detect_pkg;

  localparam int PERIOD_W      = 17;
  localparam int WIDTH_W       = 8;
  localparam int DEF_MIN_WIDTH = 8;
  localparam int DEF_MAX_WIDTH = 32;
  localparam int DEF_TIMEOUT   = 98304;

  localparam logic [PERIOD_W-1:0] GAP_MAX = '1;

  typedef enum logic [1:0] {
    WAIT_LOW = 2'd0,
    IDLE     = 2'd1,
    HIGH     = 2'd2
  } state_t;

endpackage

// File: rtl/trigger_signal_detect_sync_2ff.sv
// Two-flop synchronizer bringing an asynchronous level into clk_sys.
module sync_2ff (
  input  logic clk_sys,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/trigger_signal_detect.sv
// Trigger pulse qualifier: checks high time, measures period between valid
// pulses, tracks lock and flags missing triggers.
//
//   state    | meaning
//   WAIT_LOW | discard any high level until the input is seen low
//   IDLE     | input low, waiting for a rising edge
//   HIGH     | input high, counting pulse width
module trigger_signal_detect
  import trigger_signal_detect_pkg::*;
#(
  parameter int MIN_WIDTH = DEF_MIN_WIDTH,
  parameter int MAX_WIDTH = DEF_MAX_WIDTH,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic                clk_sys,
  input  logic                rst_n,
  input  logic                trigger_in,
  output logic                trig_valid,
  output logic [WIDTH_W-1:0]  pulse_width,
  output logic [PERIOD_W-1:0] period,
  output logic                locked,
  output logic                width_err,
  output logic                timeout_err
);

  localparam logic [WIDTH_W-1:0]  MIN_W     = WIDTH_W'(MIN_WIDTH);
  localparam logic [WIDTH_W-1:0]  MAX_W     = WIDTH_W'(MAX_WIDTH);
  localparam logic [PERIOD_W-1:0] TIMEOUT_C = PERIOD_W'(TIMEOUT);

  state_t              state;
  logic                sync;
  logic [1:0]          primed;
  logic [WIDTH_W-1:0]  width_cnt;
  logic [PERIOD_W-1:0] gap_cnt;
  logic                has_prev;
  logic                over_max, fall_ok, fall_bad, hit_timeout;

  sync_2ff u_sync (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .d       (trigger_in),
    .q       (sync)
  );

  assign over_max    = (state == HIGH) && sync && (width_cnt >= MAX_W);
  assign fall_ok     = (state == HIGH) && !sync && (width_cnt >= MIN_W) && (width_cnt <= MAX_W);
  assign fall_bad    = (state == HIGH) && !sync && !fall_ok;
  assign hit_timeout = (gap_cnt == TIMEOUT_C);

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state       <= WAIT_LOW;
      primed      <= 2'b00;
      width_cnt   <= '0;
      gap_cnt     <= '0;
      has_prev    <= 1'b0;
      trig_valid  <= 1'b0;
      pulse_width <= '0;
      period      <= '0;
      locked      <= 1'b0;
      width_err   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      // sync still holds its reset value for two edges; don't trust a low until it has filled
      primed      <= {primed[0], 1'b1};
      trig_valid  <= 1'b0;
      width_err   <= 1'b0;
      timeout_err <= 1'b0;

      case (state)
        WAIT_LOW: if (primed[1] && !sync) state <= IDLE;
        IDLE: begin
          if (sync) begin
            state     <= HIGH;
            width_cnt <= WIDTH_W'(1);
          end
        end
        HIGH: begin
          if (sync) begin
            if (over_max) begin
              width_err <= 1'b1;
              state     <= WAIT_LOW;
            end else begin
              width_cnt <= width_cnt + WIDTH_W'(1);
            end
          end else begin
            state <= IDLE;
            if (fall_ok) begin
              trig_valid  <= 1'b1;
              pulse_width <= width_cnt;
            end else begin
              width_err <= 1'b1;
            end
          end
        end
        default: state <= WAIT_LOW;
      endcase

      if (fall_ok) begin
        gap_cnt  <= PERIOD_W'(1);
        has_prev <= 1'b1;
        if (has_prev) begin
          period <= gap_cnt;
          locked <= 1'b1;
        end
      end else begin
        if (gap_cnt != GAP_MAX) gap_cnt <= gap_cnt + PERIOD_W'(1);
        // a width error already drops lock, so it absorbs a coincident timeout
        if (over_max || fall_bad) begin
          locked   <= 1'b0;
          has_prev <= 1'b0;
        end else if (hit_timeout) begin
          timeout_err <= 1'b1;
          locked      <= 1'b0;
          has_prev    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_trigger_signal_detect.sv
// Directed bench for trigger_signal_detect; TIMEOUT and generator period are
// scaled down so the whole run stays short.
module tb_trigger_signal_detect;
  import trigger_signal_detect_pkg::*;

  localparam int T_MIN   = 8;
  localparam int T_MAX   = 32;
  localparam int T_TO    = 10000;
  localparam int GEN_PER = 4096;
  localparam int LAT     = 3;

  logic                clk_sys = 1'b0;
  logic                rst_n = 1'b0;
  logic                trigger_in = 1'b0;
  logic                trig_valid, locked, width_err, timeout_err;
  logic [WIDTH_W-1:0]  pulse_width;
  logic [PERIOD_W-1:0] period;

  trigger_signal_detect #(.MIN_WIDTH(T_MIN), .MAX_WIDTH(T_MAX), .TIMEOUT(T_TO)) dut (
    .clk_sys     (clk_sys),
    .rst_n       (rst_n),
    .trigger_in  (trigger_in),
    .trig_valid  (trig_valid),
    .pulse_width (pulse_width),
    .period      (period),
    .locked      (locked),
    .width_err   (width_err),
    .timeout_err (timeout_err)
  );

  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  int tv_cnt = 0, we_cnt = 0, te_cnt = 0, tv_cyc = 0, te_cyc = 0, excl_viol = 0;
  always @(negedge clk_sys) begin
    if (trig_valid) begin tv_cnt++; tv_cyc = cyc; end
    if (width_err) we_cnt++;
    if (timeout_err) begin te_cnt++; te_cyc = cyc; end
    if (int'(trig_valid) + int'(width_err) + int'(timeout_err) > 1) excl_viol++;
  end

  int n_cmp = 0, n_bad = 0, fall_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    tv_cnt = 0; we_cnt = 0; te_cnt = 0;
  endtask

  // caller is at a negedge; returns at a negedge
  task automatic send_pulse(input int hi, input int lo);
    trigger_in = 1'b1;
    repeat (hi) @(negedge clk_sys);
    trigger_in = 1'b0;
    fall_cyc = cyc;
    repeat (lo) @(negedge clk_sys);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk_sys);
    rst_n = 1'b1;
    repeat (5) @(negedge clk_sys);
  endtask

  typedef struct {
    int hi;
    int exp_tv;
    int exp_we;
    int exp_pw;
    int exp_lock;
  } vec_t;

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{14, 1, 0, 14, 0};
    vecs[1]  = '{ 8, 1, 0,  8, 1};
    vecs[2]  = '{32, 1, 0, 32, 1};
    vecs[3]  = '{ 5, 0, 1, 32, 0};
    vecs[4]  = '{ 7, 0, 1, 32, 0};
    vecs[5]  = '{ 9, 1, 0,  9, 0};
    vecs[6]  = '{33, 0, 1,  9, 0};
    vecs[7]  = '{40, 0, 1,  9, 0};
    vecs[8]  = '{ 1, 0, 1,  9, 0};
    vecs[9]  = '{31, 1, 0, 31, 0};
    vecs[10] = '{14, 1, 0, 14, 1};

    // values held during reset
    repeat (3) @(negedge clk_sys);
    check("rst_trig_valid", 32'(trig_valid), 0);
    check("rst_pulse_width", 32'(pulse_width), 0);
    check("rst_period", 32'(period), 0);
    check("rst_locked", 32'(locked), 0);
    check("rst_width_err", 32'(width_err), 0);
    check("rst_timeout_err", 32'(timeout_err), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk_sys);

    for (int i = 0; i < 11; i++) begin
      clear_mon();
      send_pulse(vecs[i].hi, 20);
      check($sformatf("v%0d_tv", i), tv_cnt, vecs[i].exp_tv);
      check($sformatf("v%0d_we", i), we_cnt, vecs[i].exp_we);
      check($sformatf("v%0d_pw", i), 32'(pulse_width), vecs[i].exp_pw);
      check($sformatf("v%0d_lock", i), 32'(locked), vecs[i].exp_lock);
      if (vecs[i].exp_tv != 0) check($sformatf("v%0d_lat", i), tv_cyc - fall_cyc, LAT);
    end

    // reset in the middle of a pulse
    clear_mon();
    trigger_in = 1'b1;
    repeat (10) @(negedge clk_sys);
    rst_n = 1'b0;
    trigger_in = 1'b0;
    repeat (3) @(negedge clk_sys);
    rst_n = 1'b1;
    repeat (20) @(negedge clk_sys);
    check("midrst_we", we_cnt, 0);
    check("midrst_tv", tv_cnt, 0);
    check("midrst_pw", 32'(pulse_width), 0);
    check("midrst_lock", 32'(locked), 0);

    // reset released while trigger is high
    clear_mon();
    trigger_in = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk_sys);
    rst_n = 1'b1;
    repeat (12) @(negedge clk_sys);
    trigger_in = 1'b0;
    repeat (20) @(negedge clk_sys);
    check("partial_tv", tv_cnt, 0);
    check("partial_we", we_cnt, 0);
    clear_mon();
    send_pulse(14, 20);
    check("after_partial_tv", tv_cnt, 1);
    check("after_partial_pw", 32'(pulse_width), 14);
    check("after_partial_lat", tv_cyc - fall_cyc, LAT);

    // generator: 14-cycle pulses every GEN_PER cycles
    do_reset();
    for (int p = 0; p < 3; p++) begin
      clear_mon();
      send_pulse(14, 20);
      check($sformatf("gen%0d_tv", p), tv_cnt, 1);
      check($sformatf("gen%0d_pw", p), 32'(pulse_width), 14);
      check($sformatf("gen%0d_period", p), 32'(period), (p == 0) ? 0 : GEN_PER);
      check($sformatf("gen%0d_lock", p), 32'(locked), (p == 0) ? 0 : 1);
      if (p < 2) repeat (GEN_PER - 34) @(negedge clk_sys);
    end

    // short pulse after lock
    clear_mon();
    send_pulse(5, 20);
    check("short_we", we_cnt, 1);
    check("short_tv", tv_cnt, 0);
    check("short_lock", 32'(locked), 0);
    check("short_pw", 32'(pulse_width), 14);

    // lock, then input stuck low
    send_pulse(14, 100);
    send_pulse(14, 20);
    check("to_prelock", 32'(locked), 1);
    clear_mon();
    repeat (T_TO + 200) @(negedge clk_sys);
    check("to_count", te_cnt, 1);
    check("to_cycle", te_cyc, fall_cyc + LAT + T_TO);
    check("to_lock", 32'(locked), 0);
    repeat (3000) @(negedge clk_sys);
    check("to_norepeat", te_cnt, 1);

    // valid trigger landing exactly on the timeout edge
    clear_mon();
    send_pulse(14, T_TO - 14);
    send_pulse(14, 30);
    check("coll_tv", tv_cnt, 2);
    check("coll_te", te_cnt, 0);
    check("coll_period", 32'(period), T_TO);
    check("coll_lock", 32'(locked), 1);

    check("mutex", excl_viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
